// File: rtl/cache_port_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the cache port.
// The slave modport is the arbiter view; master is the requester/cache view.
interface cache_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          p0_rd;
    logic          p0_wr;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_rd;
    logic          p1_wr;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] c_word_addr;
    logic [DW-1:0] c_data_in;
    logic          c_mem_read;
    logic          c_mem_write;
    logic          c_stall;
    logic [DW-1:0] c_data_out;

    logic          busy;
    logic          grant_id;
    logic          err;

    modport slave (
        input  p0_rd, p0_wr, p0_addr, p0_wdata,
        input  p1_rd, p1_wr, p1_addr, p1_wdata,
        input  c_stall, c_data_out,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output c_word_addr, c_data_in,
        output c_mem_read, c_mem_write,
        output busy, grant_id, err
    );

    modport master (
        output p0_rd, p0_wr, p0_addr, p0_wdata,
        output p1_rd, p1_wr, p1_addr, p1_wdata,
        output c_stall, c_data_out,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  c_word_addr, c_data_in,
        input  c_mem_read, c_mem_write,
        input  busy, grant_id, err
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin two-port arbiter in front of a single write-through cache port.
// Optional WAIT timeout abort when ARB_TIMEOUT_EN is defined.
module cache_port_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TMO_CYC = 64
) (
    input logic                 clk,
    input logic                 reset,
    cache_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic req0, req1, pick;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    assign req0 = bus.p0_rd | bus.p0_wr;
    assign req1 = bus.p1_rd | bus.p1_wr;
    // On contention the port that did not win last time goes first
    assign pick = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    addr_d  = pick ? bus.p1_addr : bus.p0_addr;
                    wdata_d = pick ? bus.p1_wdata : bus.p0_wdata;
                    wr_d    = pick ? bus.p1_wr : bus.p0_wr;
                    state_d = ISSUE;
`ifdef ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            WAIT: begin
                if (!bus.c_stall) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        if (gnt_q) rdata1_d = bus.c_data_out;
                        else       rdata0_d = bus.c_data_out;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TMO_CYC)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.c_word_addr = addr_q;
    assign bus.c_data_in   = wdata_q;
    assign bus.c_mem_read  = (state_q == ISSUE) & ~wr_q;
    assign bus.c_mem_write = (state_q == ISSUE) & wr_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.grant_id    = gnt_q;
    assign bus.p0_ack      = (state_q == RESP) & ~gnt_q;
    assign bus.p1_ack      = (state_q == RESP) & gnt_q;
    assign bus.p0_rdata    = rdata0_q;
    assign bus.p1_rdata    = rdata1_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err         = (state_q == RESP) & err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus a
// randomized two-port run scored against a transaction-level memory model.
module tb_cache_port_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   stall_cfg = 0;
    bit   stuck = 0;
    int   rem = 0;
    bit   minit = 0;

    logic [DW-1:0] cmem [1024];
    logic [DW-1:0] rmem [1024];
    logic [DW-1:0] exp_rd [2];
    logic [AW-1:0] last_addr;
    logic          last_wr;
    logic [DW-1:0] last_data;

    always #5 clk = ~clk;

    cache_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    cache_port_arbiter #(
        .AW(AW), .DW(DW), .TMO_CYC(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] pat(int i);
        return 32'hC0DE0000 ^ DW'(i * 37);
    endfunction

    // Cache model: stall for stall_cfg cycles after each pulse
    always @(negedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 1024; i++) cmem[i] = pat(i);
            minit = 1;
        end
        if (reset) begin
            rem = 0;
            bus.c_stall = 1'b0;
            bus.c_data_out = '0;
        end else if (bus.c_mem_read | bus.c_mem_write) begin
            last_addr = bus.c_word_addr;
            last_wr   = bus.c_mem_write;
            last_data = bus.c_data_in;
            if (bus.c_mem_write) cmem[bus.c_word_addr] = bus.c_data_in;
            else bus.c_data_out = cmem[bus.c_word_addr];
            rem = stall_cfg;
        end else if (stuck || rem > 0) begin
            bus.c_stall = 1'b1;
            if (rem > 0) rem--;
        end else begin
            bus.c_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int p, logic rd, logic wr,
                       logic [AW-1:0] a, logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_rd = rd; bus.p0_wr = wr;
            bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_rd = rd; bus.p1_wr = wr;
            bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    task automatic test_reset();
        int acks = 0;
        reset = 1'b1;
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);
        stuck = 0;
        stall_cfg = 0;
        step(); step();
        tests++;
        if ({bus.p0_ack, bus.p1_ack, bus.busy, bus.grant_id, bus.err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000",
                {bus.p0_ack, bus.p1_ack, bus.busy, bus.grant_id, bus.err});
        end
        tests++;
        if ({bus.p0_rdata, bus.p1_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_rdata: got %h %h want 0", bus.p0_rdata, bus.p1_rdata);
        end
        tests++;
        if ({bus.c_mem_read, bus.c_mem_write, bus.c_word_addr, bus.c_data_in} !== '0) begin
            fails++;
            $display("FAIL reset_cache: rd %b wr %b addr %h data %h want 0",
                bus.c_mem_read, bus.c_mem_write, bus.c_word_addr, bus.c_data_in);
        end
        reset = 1'b0;
        step();
        stuck = 1;
        drv(0, 1, 0, 10'h004, '0);
        step(); step(); step();
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midflight_busy: got %b want 1", bus.busy);
        end
        reset = 1'b1;
        step(); step();
        tests++;
        if ({bus.busy, bus.p0_ack, bus.p1_ack, bus.c_mem_read,
             bus.c_mem_write, bus.grant_id, bus.err} !== 7'b0) begin
            fails++;
            $display("FAIL midflight_reset: got %b want 0000000",
                {bus.busy, bus.p0_ack, bus.p1_ack, bus.c_mem_read,
                 bus.c_mem_write, bus.grant_id, bus.err});
        end
        reset = 1'b0;
        drv(0, 0, 0, '0, '0);
        stuck = 0;
        repeat (8) begin
            step();
            if (bus.p0_ack | bus.p1_ack) acks++;
        end
        tests++;
        if (acks != 0) begin
            fails++;
            $display("FAIL reset_no_ack: got %0d acks want 0", acks);
        end
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic test_hit();
        stall_cfg = 0;
        drv(0, 1, 0, 10'h001, '0);
        step();
        tests++;
        if ({bus.c_mem_read, bus.c_mem_write, bus.busy, bus.grant_id} !== 4'b1010
            || bus.c_word_addr !== 10'h001) begin
            fails++;
            $display("FAIL hit_issue: rd/wr/busy/gnt %b addr %h want 1010 001",
                {bus.c_mem_read, bus.c_mem_write, bus.busy, bus.grant_id},
                bus.c_word_addr);
        end
        step();
        tests++;
        if ({bus.c_mem_read, bus.p0_ack} !== 2'b00) begin
            fails++;
            $display("FAIL hit_pulse_len: rd/ack %b want 00",
                {bus.c_mem_read, bus.p0_ack});
        end
        step();
        tests++;
        if ({bus.p0_ack, bus.p1_ack, bus.err} !== 3'b100) begin
            fails++;
            $display("FAIL hit_ack: got %b want 100",
                {bus.p0_ack, bus.p1_ack, bus.err});
        end
        tests++;
        if (bus.p0_rdata !== rmem[1]) begin
            fails++;
            $display("FAIL hit_rdata: got %h want %h", bus.p0_rdata, rmem[1]);
        end
        exp_rd[0] = rmem[1];
        drv(0, 0, 0, '0, '0);
        step();
    endtask

    task automatic test_write_stall();
        int lat = 1;
        int extra = 0;
        int p0a = 0;
        stall_cfg = 6;
        drv(1, 0, 1, 10'h001, 32'd5);
        step();
        tests++;
        if ({bus.c_mem_write, bus.c_mem_read, bus.grant_id} !== 3'b101
            || bus.c_data_in !== 32'd5 || bus.c_word_addr !== 10'h001) begin
            fails++;
            $display("FAIL wr_issue: wr/rd/gnt %b data %0d addr %h want 101 5 001",
                {bus.c_mem_write, bus.c_mem_read, bus.grant_id},
                bus.c_data_in, bus.c_word_addr);
        end
        while (!bus.p1_ack && lat < 40) begin
            step();
            lat++;
            if (bus.c_mem_write | bus.c_mem_read) extra++;
            if (bus.p0_ack) p0a++;
        end
        tests++;
        if (lat != 9) begin
            fails++;
            $display("FAIL wr_stall_latency: got %0d want 9", lat);
        end
        tests++;
        if (extra != 0 || p0a != 0) begin
            fails++;
            $display("FAIL wr_side: extra pulses %0d p0 acks %0d want 0 0", extra, p0a);
        end
        tests++;
        if (bus.p1_rdata !== exp_rd[1]) begin
            fails++;
            $display("FAIL wr_rdata_hold: got %h want %h", bus.p1_rdata, exp_rd[1]);
        end
        rmem[1] = 32'd5;
        stall_cfg = 0;
        drv(1, 0, 0, '0, '0);
        step();
    endtask

    task automatic test_rr();
        int order[$];
        int n = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        stall_cfg = 1;
        drv(0, 1, 0, 10'h003, '0);
        drv(1, 1, 0, 10'h001, '0);
        while (order.size() < 4 && n < 80) begin
            step();
            n++;
            if (bus.p0_ack) begin
                order.push_back(0);
                tests++;
                if (bus.p0_rdata !== rmem[3]) begin
                    fails++;
                    $display("FAIL rr_rdata0: got %h want %h", bus.p0_rdata, rmem[3]);
                end
            end
            if (bus.p1_ack) begin
                order.push_back(1);
                tests++;
                if (bus.p1_rdata !== rmem[1]) begin
                    fails++;
                    $display("FAIL rr_rdata1: got %h want %h", bus.p1_rdata, rmem[1]);
                end
            end
        end
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);
        tests++;
        if (order.size() != 4) begin
            fails++;
            $display("FAIL rr_count: got %0d acks want 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            tests++;
            if (order[i] != i % 2) begin
                fails++;
                $display("FAIL rr_order[%0d]: got port %0d want %0d", i, order[i], i % 2);
            end
        end
        exp_rd[0] = rmem[3];
        exp_rd[1] = rmem[1];
        stall_cfg = 0;
        step();
    endtask

    task automatic test_rdwr();
        int n = 0;
        drv(0, 1, 1, 10'h005, 32'd15);
        step();
        tests++;
        if ({bus.c_mem_write, bus.c_mem_read} !== 2'b10 || bus.c_data_in !== 32'd15) begin
            fails++;
            $display("FAIL rdwr_op: wr/rd %b data %0d want 10 15",
                {bus.c_mem_write, bus.c_mem_read}, bus.c_data_in);
        end
        while (!bus.p0_ack && n < 20) begin
            step();
            n++;
            if (bus.c_mem_read) begin
                tests++;
                fails++;
                $display("FAIL rdwr_read_pulse: got 1 want 0");
            end
        end
        tests++;
        if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== exp_rd[0]) begin
            fails++;
            $display("FAIL rdwr_ack: ack %b rdata %h want 1 %h",
                bus.p0_ack, bus.p0_rdata, exp_rd[0]);
        end
        rmem[5] = 32'd15;
        drv(0, 0, 0, '0, '0);
        step();
    endtask

    task automatic test_timeout();
        int lat = 0;
        int acked = 0;
        stuck = 1;
        drv(0, 1, 0, 10'h002, '0);
`ifdef ARB_TIMEOUT_EN
        begin
            logic          errv = 1'b0;
            logic [DW-1:0] rd = '0;
            while (acked == 0 && lat < 40) begin
                step();
                lat++;
                if (bus.p0_ack) begin
                    acked = 1;
                    errv = bus.err;
                    rd = bus.p0_rdata;
                end
            end
            tests++;
            if (lat != 10) begin
                fails++;
                $display("FAIL tmo_latency: got %0d want 10", lat);
            end
            tests++;
            if (errv !== 1'b1 || rd !== exp_rd[0]) begin
                fails++;
                $display("FAIL tmo_err: err %b rdata %h want 1 %h", errv, rd, exp_rd[0]);
            end
            drv(0, 0, 0, '0, '0);
            stuck = 0;
            step();
            tests++;
            if (bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL tmo_idle: busy %b want 0", bus.busy);
            end
        end
`else
        begin
            int busy_low = 0;
            int err_seen = 0;
            repeat (40) begin
                step();
                lat++;
                if (bus.p0_ack | bus.p1_ack) acked++;
                if (!bus.busy) busy_low++;
                if (bus.err) err_seen++;
            end
            tests++;
            if (acked != 0 || busy_low != 0) begin
                fails++;
                $display("FAIL stuck_wait: acks %0d idle cycles %0d want 0 0",
                    acked, busy_low);
            end
            tests++;
            if (err_seen != 0) begin
                fails++;
                $display("FAIL err_tied: got %0d err cycles want 0", err_seen);
            end
            reset = 1'b1;
            drv(0, 0, 0, '0, '0);
            stuck = 0;
            step();
            reset = 1'b0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            step();
        end
`endif
    endtask

    task automatic test_random();
        bit            act [2];
        logic          wr [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dt [2];
        int            waited [2];
        int            left [2];
        int            done = 0;
        int            n = 0;
        bit            prev = 0;
        bit            pulse;
        logic          ackp;
        logic [DW-1:0] rdp;
        int            r;
        act = '{0, 0};
        waited = '{0, 0};
        left = '{30, 30};
        wr = '{0, 0};
        ad = '{'0, '0};
        dt = '{'0, '0};
        while (done < 60 && n < 4000) begin
            step();
            n++;
            pulse = bus.c_mem_read | bus.c_mem_write;
            if (pulse) begin
                tests++;
                if (prev || (bus.c_mem_read & bus.c_mem_write)) begin
                    fails++;
                    $display("FAIL rnd_pulse: prev %b rd %b wr %b want single pulse",
                        prev, bus.c_mem_read, bus.c_mem_write);
                end
            end
            prev = pulse;
            if (bus.p0_ack | bus.p1_ack) begin
                tests++;
                if (bus.p0_ack & bus.p1_ack) begin
                    fails++;
                    $display("FAIL rnd_dual_ack: got 11 want one ack");
                end
            end
            for (int p = 0; p < 2; p++) begin
                ackp = (p == 0) ? bus.p0_ack : bus.p1_ack;
                rdp  = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
                if (ackp) begin
                    tests++;
                    if (!act[p]) begin
                        fails++;
                        $display("FAIL rnd_spurious_ack: port %0d got ack want none", p);
                    end else begin
                        if (wr[p]) rmem[ad[p]] = dt[p];
                        else exp_rd[p] = rmem[ad[p]];
                        tests++;
                        if (rdp !== exp_rd[p]) begin
                            fails++;
                            $display("FAIL rnd_rdata: port %0d got %h want %h",
                                p, rdp, exp_rd[p]);
                        end
                        tests++;
                        if (last_addr !== ad[p] || last_wr !== wr[p]
                            || (wr[p] && last_data !== dt[p])) begin
                            fails++;
                            $display("FAIL rnd_cache_op: port %0d got a%h w%b d%h want a%h w%b d%h",
                                p, last_addr, last_wr, last_data, ad[p], wr[p], dt[p]);
                        end
                        tests++;
                        if (waited[p] > 1) begin
                            fails++;
                            $display("FAIL rnd_starve: port %0d waited %0d want <=1",
                                p, waited[p]);
                        end
                        if (act[1-p]) waited[1-p]++;
                        act[p] = 0;
                        done++;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && left[p] > 0 && $urandom_range(0, 2) == 0) begin
                    act[p] = 1;
                    left[p]--;
                    waited[p] = 0;
                    r = $urandom_range(0, 2);
                    wr[p] = (r != 0);
                    ad[p] = AW'($urandom_range(0, 7));
                    dt[p] = $urandom;
                    drv(p, r != 1, r != 0, ad[p], dt[p]);
                end else if (!act[p]) begin
                    drv(p, 0, 0, '0, '0);
                end
            end
            stall_cfg = $urandom_range(0, 3);
        end
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);
        tests++;
        if (done != 60) begin
            fails++;
            $display("FAIL rnd_timeout: got %0d completions want 60", done);
        end
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, '0, '0);
        drv(1, 0, 0, '0, '0);
        for (int i = 0; i < 1024; i++) rmem[i] = pat(i);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        test_reset();
        test_hit();
        test_write_stall();
        test_rr();
        test_rdwr();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
